// File: rtl/div_ctrl_if.sv
// ============================================================================
// Module : div_ctrl_if
// Purpose: Request/response bus between the execute stage and the divide
//          sequencer.
//   start, is_signed, op_a, op_b, cancel : requester -> sequencer
//   busy, done, div_zero, hi, lo         : sequencer -> requester
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_ctrl_if;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, is_signed, op_a, op_b, cancel,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, is_signed, op_a, op_b, cancel,
    output busy, done, div_zero, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/div_ctrl.sv
// ============================================================================
// Module : div_ctrl
// Purpose: Sequencer for a fixed-latency unsigned 32-bit divide core. Converts
//          MIPS DIV operands to magnitudes, issues them under the core's rfd
//          handshake, waits out the core latency, restores the signs and
//          writes HI (remainder) / LO (quotient).
// Ports  : clk, rst_n      - clock, asynchronous active-low reset
//          bus (slave)     - request/response bus, see div_ctrl_if
//          core_dividend/core_divisor - operand magnitudes to the core
//          core_rfd        - core ready-for-data
//          core_quotient/core_fractional - unsigned results from the core
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div_ctrl #(
  parameter int LATENCY = 4,
  parameter int CNT_W   = 3
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  div_ctrl_if.slave        bus,
  output logic [31:0]      core_dividend,
  output logic [31:0]      core_divisor,
  input  wire logic        core_rfd,
  input  wire logic [31:0] core_quotient,
  input  wire logic [31:0] core_fractional
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ZERO  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_quot;  // quotient sign: a and b signs differ
  logic             r_neg_rem;   // remainder takes the dividend's sign
  logic [31:0]      r_zero_a;    // raw dividend kept for the divide-by-zero result

  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_accept;

  assign w_a_neg  = bus.is_signed & bus.op_a[31];
  assign w_b_neg  = bus.is_signed & bus.op_b[31];
  // Negation mod 2^32 leaves 0x8000_0000 as its own magnitude, which is exact.
  assign w_mag_a  = w_a_neg ? -bus.op_a : bus.op_a;
  assign w_mag_b  = w_b_neg ? -bus.op_b : bus.op_b;
  assign w_quot   = r_neg_quot ? -core_quotient   : core_quotient;
  assign w_rem    = r_neg_rem  ? -core_fractional : core_fractional;
  // A cancel coinciding with a new request drops that request.
  assign w_accept = bus.start & ~bus.cancel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_neg_quot    <= 1'b0;
      r_neg_rem     <= 1'b0;
      r_zero_a      <= '0;
      core_dividend <= '0;
      core_divisor  <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.div_zero  <= 1'b0;
      bus.hi        <= '0;
      bus.lo        <= '0;
    end else begin
      bus.done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept && (bus.op_b == 32'd0)) begin
            // Core is bypassed; the result is written one edge later from
            // S_ZERO, which stalls the pipeline for that cycle.
            r_zero_a <= bus.op_a;
            bus.busy <= 1'b1;
            r_state  <= S_ZERO;
          end else if (w_accept) begin
            core_dividend <= w_mag_a;
            core_divisor  <= w_mag_b;
            r_neg_quot    <= w_a_neg ^ w_b_neg;
            r_neg_rem     <= w_a_neg;
            bus.busy      <= 1'b1;
            r_state       <= S_ISSUE;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_ISSUE: begin
          if (bus.cancel) begin
            bus.busy <= 1'b0;
            r_state  <= S_IDLE;
          end else if (core_rfd) begin
            // The core samples the operands on this edge.
            r_cnt   <= c_cnt_load;
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (bus.cancel) begin
            bus.busy <= 1'b0;
            r_state  <= S_IDLE;
          end else if (r_cnt == '0) begin
            bus.hi       <= w_rem;
            bus.lo       <= w_quot;
            bus.div_zero <= 1'b0;
            bus.done     <= 1'b1;
            bus.busy     <= 1'b0;
            r_state      <= S_DONE;
          end else begin
            r_cnt <= r_cnt - c_cnt_one;
          end
        end

        S_ZERO: begin
          if (bus.cancel) begin
            bus.busy <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            bus.hi       <= r_zero_a;
            bus.lo       <= 32'hFFFF_FFFF;
            bus.div_zero <= 1'b1;
            bus.done     <= 1'b1;
            bus.busy     <= 1'b0;
            r_state      <= S_DONE;
          end
        end

        default: begin
          bus.busy <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_ctrl.sv
// ============================================================================
// Module : tb_div_ctrl
// Purpose: Self-checking bench for div_ctrl with a behavioural fixed-latency
//          divide core. Expected results are queued when a request is issued
//          and compared when done pulses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_ctrl;
  localparam int LAT = 4;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
    int          bsy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] core_dividend;
  logic [31:0] core_divisor;
  logic        core_rfd = 1'b1;
  logic [31:0] core_quotient;
  logic [31:0] core_fractional;

  int   cyc = 0;
  int   busy_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  logic [31:0] pipe_q [LAT];
  logic [31:0] pipe_r [LAT];

  div_ctrl_if bus ();

  div_ctrl #(.LATENCY(LAT), .CNT_W(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .core_dividend   (core_dividend),
    .core_divisor    (core_divisor),
    .core_rfd        (core_rfd),
    .core_quotient   (core_quotient),
    .core_fractional (core_fractional)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core: stage 0 samples on an rfd edge, result visible after
  // LAT-1 further edges so the sequencer's capture edge sees it.
  always @(posedge clk) begin
    if (core_rfd && core_divisor != 32'd0) begin
      pipe_q[0] <= core_dividend / core_divisor;
      pipe_r[0] <= core_dividend % core_divisor;
    end else begin
      pipe_q[0] <= 32'hDEAD_BEEF;
      pipe_r[0] <= 32'hDEAD_BEEF;
    end
    for (int i = 1; i < LAT; i++) begin
      pipe_q[i] <= pipe_q[i-1];
      pipe_r[i] <= pipe_r[i-1];
    end
  end
  assign core_quotient   = pipe_q[LAT-1];
  assign core_fractional = pipe_r[LAT-1];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("hi", {32'd0, bus.hi}, {32'd0, e.hi});
          check("lo", {32'd0, bus.lo}, {32'd0, e.lo});
          check("div_zero", {63'd0, bus.div_zero}, {63'd0, e.dz});
          check("done_cycle", 64'(cyc), 64'(e.cyc));
          check("busy_cycles", 64'(busy_cnt), 64'(e.bsy));
        end
        busy_cnt = 0;
      end
    end
  end

  // Called at a negedge. ed/ev are the core operands expected right after the
  // request edge (unchanged prior values for a divide by zero).
  task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input logic [31:0] ed, input logic [31:0] ev,
                       input logic [31:0] eh, input logic [31:0] el, input logic ez);
    exp_t e;
    int   n;
    bus.start = 1'b1;
    bus.is_signed = sgn;
    bus.op_a = a;
    bus.op_b = b;
    if (hold > 0) core_rfd = 1'b0;
    @(posedge clk);
    #1 n = cyc;
    e.hi = eh; e.lo = el; e.dz = ez;
    e.cyc = (b == 32'd0) ? n + 1 : n + LAT + 1 + hold;
    e.bsy = (b == 32'd0) ? 1 : LAT + 1 + hold;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    check("core_dividend", {32'd0, core_dividend}, {32'd0, ed});
    check("core_divisor", {32'd0, core_divisor}, {32'd0, ev});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_dividend", {32'd0, core_dividend}, {32'd0, ed});
      check("hold_divisor", {32'd0, core_divisor}, {32'd0, ev});
    end
    core_rfd = 1'b1;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    if (k == 40) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin : main
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.cancel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outs", {59'd0, bus.busy, bus.done, bus.div_zero, 2'b00}, 64'd0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("rst_core", {core_dividend, core_divisor}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(1'b0, 32'd1, 32'd1, 0, 32'd1, 32'd1, 32'd0, 32'd1, 1'b0);
    drain();
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    drain();
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 32'd7, 32'd2, 32'd1, 32'hFFFF_FFFD, 1'b0);
    drain();
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 32'd1, 32'd0, 32'h8000_0000, 1'b0);
    drain();
    do_op(1'b0, 32'hFFFF_FFFF, 32'h10, 0, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 1'b0);
    drain();
    do_op(1'b0, 32'd5, 32'd0, 0, 32'hFFFF_FFFF, 32'h10, 32'd5, 32'hFFFF_FFFF, 1'b1);
    drain();
    do_op(1'b0, 32'd100, 32'd7, 3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    drain();
    do_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 0, 32'd100, 32'd7, 32'hFFFF_FFFE, 32'd14, 1'b0);
    drain();

    // Cancel in the second WAIT cycle; prior hi/lo = 0xFFFF_FFFE / 14.
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.op_a = 32'd50; bus.op_b = 32'd3;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); bus.cancel = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.cancel = 1'b0;
    busy_cnt = 0;
    check("cancel_busy", {63'd0, bus.busy}, 64'd0);
    check("cancel_hilo", {bus.hi, bus.lo}, {32'hFFFF_FFFE, 32'd14});
    check("cancel_dz", {63'd0, bus.div_zero}, 64'd0);
    do_op(1'b0, 32'd9, 32'd4, 0, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0);
    drain();

    // Asynchronous reset in the middle of WAIT.
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.op_a = 32'd1000; bus.op_b = 32'd10;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_outs", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd0);
    check("arst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("arst_core", {core_dividend, core_divisor}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    busy_cnt = 0;
    sb.delete();
    @(negedge clk);
    do_op(1'b1, 32'hFFFF_FFF7, 32'd0, 0, 32'd0, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1);
    drain();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
